// File: rtl/lat_stat_pkg.sv
// Shared defaults and the per-channel latency statistics record.
// Record fields are sized by the package defaults; the monitor casts to its own parameters.
package lat_stat_pkg;

   localparam int unsigned LS_NUM_CH    = 4;
   localparam int unsigned LS_TS_WIDTH  = 16;
   localparam int unsigned LS_SUM_WIDTH = 32;
   localparam int unsigned LS_CNT_WIDTH = 24;
   localparam int unsigned LS_DEPTH     = 8;

   typedef struct packed {
      logic [LS_CNT_WIDTH-1:0] cnt;
      logic [LS_SUM_WIDTH-1:0] sum;
      logic [LS_TS_WIDTH-1:0]  min;
      logic [LS_TS_WIDTH-1:0]  max;
   } lat_stat_rec_t;

   // Empty-statistics value: min carries the all-ones sentinel until the first sample.
   function automatic lat_stat_rec_t stat_rec_init();
      lat_stat_rec_t r;
      r.cnt = '0;
      r.sum = '0;
      r.min = '1;
      r.max = '0;
      return r;
   endfunction

endpackage

// File: rtl/lat_stat_monitor_if.sv
// Event and readout bundle of the latency statistics monitor.
interface lat_stat_monitor_if
   import lat_stat_pkg::*;
#(
   parameter int unsigned NUM_CH    = LS_NUM_CH,
   parameter int unsigned TS_WIDTH  = LS_TS_WIDTH,
   parameter int unsigned SUM_WIDTH = LS_SUM_WIDTH,
   parameter int unsigned CNT_WIDTH = LS_CNT_WIDTH,
   parameter int unsigned DEPTH     = LS_DEPTH
) ();

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned OUT_W = $clog2(DEPTH) + 1;

   logic                 en;
   logic                 clr;
   logic [NUM_CH-1:0]    req_fire;
   logic [NUM_CH-1:0]    rsp_fire;
   logic [CH_W-1:0]      rd_ch;
   logic [CNT_WIDTH-1:0] rd_cnt;
   logic [TS_WIDTH-1:0]  rd_min;
   logic [TS_WIDTH-1:0]  rd_max;
   logic [SUM_WIDTH-1:0] rd_sum;
   logic [OUT_W-1:0]     rd_outst;
   logic [NUM_CH-1:0]    err_ovf;
   logic [NUM_CH-1:0]    err_unf;

   modport master (
      output en, clr, req_fire, rsp_fire, rd_ch,
      input  rd_cnt, rd_min, rd_max, rd_sum, rd_outst, err_ovf, err_unf
   );

   modport slave (
      input  en, clr, req_fire, rsp_fire, rd_ch,
      output rd_cnt, rd_min, rd_max, rd_sum, rd_outst, err_ovf, err_unf
   );

endinterface

// File: rtl/lat_ts_fifo.sv
// Timestamp FIFO for one channel; head_c is the combinational view of the oldest entry.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module lat_ts_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       head_c,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             full_q;
   logic             empty_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop  = pop & ~empty_q;
      do_push = push & (~full_q | do_pop);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Pointers and registered occupancy flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr_q] <= din;
   end

   assign head_c = mem[rd_ptr_q];
   assign full   = full_q;
   assign empty  = empty_q;
   assign count  = count_q;

endmodule

// File: rtl/lat_stat_monitor.sv
// Per-channel request/response latency monitor: timestamps requests, measures
// latency on responses, and keeps count/sum/min/max with a registered readout port.
module lat_stat_monitor
   import lat_stat_pkg::*;
#(
   parameter int unsigned NUM_CH    = LS_NUM_CH,
   parameter int unsigned TS_WIDTH  = LS_TS_WIDTH,
   parameter int unsigned SUM_WIDTH = LS_SUM_WIDTH,
   parameter int unsigned CNT_WIDTH = LS_CNT_WIDTH,
   parameter int unsigned DEPTH     = LS_DEPTH
) (
   input logic               clk,
   input logic               rst_n,
   lat_stat_monitor_if.slave bus
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned OUT_W = $clog2(DEPTH) + 1;

   logic [TS_WIDTH-1:0]  tick_q;
   logic                 live;
   logic [NUM_CH-1:0]    push;
   logic [NUM_CH-1:0]    pop;
   logic [NUM_CH-1:0]    ovf_evt;
   logic [NUM_CH-1:0]    unf_evt;
   logic [NUM_CH-1:0]    full;
   logic [NUM_CH-1:0]    empty;
   logic [TS_WIDTH-1:0]  head [NUM_CH];
   logic [OUT_W-1:0]     ch_count [NUM_CH];
   logic [TS_WIDTH-1:0]  lat [NUM_CH];
   logic [SUM_WIDTH:0]   sum_ext [NUM_CH];
   lat_stat_rec_t        stat_q [NUM_CH];
   lat_stat_rec_t        stat_d [NUM_CH];
   logic [NUM_CH-1:0]    err_ovf_q;
   logic [NUM_CH-1:0]    err_unf_q;
   lat_stat_rec_t        rd_sel;
   logic [OUT_W-1:0]     outst_sel;
   logic [CNT_WIDTH-1:0] rd_cnt_q;
   logic [TS_WIDTH-1:0]  rd_min_q;
   logic [TS_WIDTH-1:0]  rd_max_q;
   logic [SUM_WIDTH-1:0] rd_sum_q;
   logic [OUT_W-1:0]     rd_outst_q;

   // Free-running timestamp; frozen while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       tick_q <= '0;
      else if (bus.clr) tick_q <= '0;
      else if (bus.en)  tick_q <= tick_q + TS_WIDTH'(1);
   end

   // Event qualification; clr swallows every event of its cycle.
   always_comb begin
      live    = bus.en & ~bus.clr;
      pop     = bus.rsp_fire & ~empty & {NUM_CH{live}};
      unf_evt = bus.rsp_fire & empty & {NUM_CH{live}};
      push    = bus.req_fire & (~full | pop) & {NUM_CH{live}};
      ovf_evt = bus.req_fire & full & ~pop & {NUM_CH{live}};
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      lat_ts_fifo #(
         .DEPTH (DEPTH),
         .WIDTH (TS_WIDTH)
      ) u_fifo (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (bus.clr),
         .push   (push[i]),
         .pop    (pop[i]),
         .din    (tick_q),
         .head_c (head[i]),
         .full   (full[i]),
         .empty  (empty[i]),
         .count  (ch_count[i])
      );
   end

   // Statistics update on a valid pop; count and sum saturate.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         stat_d[i]  = stat_q[i];
         lat[i]     = tick_q - head[i];
         sum_ext[i] = {1'b0, SUM_WIDTH'(stat_q[i].sum)} + (SUM_WIDTH+1)'(lat[i]);
         if (pop[i]) begin
            if (CNT_WIDTH'(stat_q[i].cnt) != {CNT_WIDTH{1'b1}})
               stat_d[i].cnt = LS_CNT_WIDTH'(CNT_WIDTH'(stat_q[i].cnt) + CNT_WIDTH'(1));
            stat_d[i].sum = sum_ext[i][SUM_WIDTH] ? LS_SUM_WIDTH'({SUM_WIDTH{1'b1}})
                                                  : LS_SUM_WIDTH'(sum_ext[i][SUM_WIDTH-1:0]);
            if (lat[i] < TS_WIDTH'(stat_q[i].min)) stat_d[i].min = LS_TS_WIDTH'(lat[i]);
            if (lat[i] > TS_WIDTH'(stat_q[i].max)) stat_d[i].max = LS_TS_WIDTH'(lat[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) stat_q[i] <= stat_rec_init();
         err_ovf_q <= '0;
         err_unf_q <= '0;
      end else if (bus.clr) begin
         for (int i = 0; i < NUM_CH; i++) stat_q[i] <= stat_rec_init();
         err_ovf_q <= '0;
         err_unf_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) stat_q[i] <= stat_d[i];
         err_ovf_q <= err_ovf_q | ovf_evt;
         err_unf_q <= err_unf_q | unf_evt;
      end
   end

   // Readout select; an out-of-range channel reads as empty statistics.
   always_comb begin
      rd_sel    = stat_rec_init();
      outst_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.rd_ch == CH_W'(i)) begin
            rd_sel    = stat_q[i];
            outst_sel = ch_count[i];
         end
      end
   end

   // Readout registers follow clr one edge later, so they are reset-only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q   <= '0;
         rd_min_q   <= '0;
         rd_max_q   <= '0;
         rd_sum_q   <= '0;
         rd_outst_q <= '0;
      end else begin
         rd_cnt_q   <= CNT_WIDTH'(rd_sel.cnt);
         rd_min_q   <= TS_WIDTH'(rd_sel.min);
         rd_max_q   <= TS_WIDTH'(rd_sel.max);
         rd_sum_q   <= SUM_WIDTH'(rd_sel.sum);
         rd_outst_q <= outst_sel;
      end
   end

   assign bus.rd_cnt   = rd_cnt_q;
   assign bus.rd_min   = rd_min_q;
   assign bus.rd_max   = rd_max_q;
   assign bus.rd_sum   = rd_sum_q;
   assign bus.rd_outst = rd_outst_q;
   assign bus.err_ovf  = err_ovf_q;
   assign bus.err_unf  = err_unf_q;

endmodule

// File: tb/tb_lat_stat_monitor.sv
// Directed bench for lat_stat_monitor: cycle table on the default build plus a
// narrow build that exercises timestamp wrap and count/sum saturation.
module tb_lat_stat_monitor;

   logic clk = 1'b0;
   logic rst_n;

   lat_stat_monitor_if #(.NUM_CH(4), .TS_WIDTH(16), .SUM_WIDTH(32), .CNT_WIDTH(24), .DEPTH(8)) bus ();
   lat_stat_monitor #(.NUM_CH(4), .TS_WIDTH(16), .SUM_WIDTH(32), .CNT_WIDTH(24), .DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   lat_stat_monitor_if #(.NUM_CH(2), .TS_WIDTH(4), .SUM_WIDTH(4), .CNT_WIDTH(2), .DEPTH(4)) sbus ();
   lat_stat_monitor #(.NUM_CH(2), .TS_WIDTH(4), .SUM_WIDTH(4), .CNT_WIDTH(2), .DEPTH(4)) sdut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sbus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  req;
      logic [3:0]  rsp;
      logic [1:0]  ch;
      int          rep;
      bit          chk;
      logic [23:0] cnt;
      logic [15:0] mn;
      logic [15:0] mx;
      logic [31:0] sum;
      logic [3:0]  outst;
      logic [3:0]  ovf;
      logic [3:0]  unf;
   } vec_t;

   vec_t tbl [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_main(input string tag, input logic [23:0] cnt, input logic [15:0] mn,
                             input logic [15:0] mx, input logic [31:0] sum, input logic [3:0] outst,
                             input logic [3:0] ovf, input logic [3:0] unf);
      check({tag, ".cnt"},   64'(bus.rd_cnt),   64'(cnt));
      check({tag, ".min"},   64'(bus.rd_min),   64'(mn));
      check({tag, ".max"},   64'(bus.rd_max),   64'(mx));
      check({tag, ".sum"},   64'(bus.rd_sum),   64'(sum));
      check({tag, ".outst"}, 64'(bus.rd_outst), 64'(outst));
      check({tag, ".ovf"},   64'(bus.err_ovf),  64'(ovf));
      check({tag, ".unf"},   64'(bus.err_unf),  64'(unf));
   endtask

   task automatic step(input logic en, input logic clr, input logic [3:0] req,
                       input logic [3:0] rsp, input logic [1:0] ch);
      bus.en       = en;
      bus.clr      = clr;
      bus.req_fire = req;
      bus.rsp_fire = rsp;
      bus.rd_ch    = ch;
      @(posedge clk);
      #1;
   endtask

   task automatic s_step(input logic en, input logic [1:0] req, input logic [1:0] rsp);
      sbus.en       = en;
      sbus.clr      = 1'b0;
      sbus.req_fire = req;
      sbus.rsp_fire = rsp;
      sbus.rd_ch    = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] s_cnt_exp [4];
      logic [3:0] s_sum_exp [4];
      s_cnt_exp[0] = 2'd1; s_cnt_exp[1] = 2'd2; s_cnt_exp[2] = 2'd3; s_cnt_exp[3] = 2'd3;
      s_sum_exp[0] = 4'd4; s_sum_exp[1] = 4'd8; s_sum_exp[2] = 4'd12; s_sum_exp[3] = 4'd15;

      // en, req, rsp, ch, rep, chk, cnt, min, max, sum, outst, ovf, unf
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd0, 10, 1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h1, 4'h0, 2'd0, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd0, 4,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd1, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h1, 2'd0, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd1, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd0, 1,  1'b1, 24'd1, 16'd5,    16'd5, 32'd5, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h2, 4'h0, 2'd1, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h2, 4'h0, 2'd1, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h2, 4'h0, 2'd1, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd2, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h2, 2'd1, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd1, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h2, 2'd1, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd1, 3,  1'b1, 24'd2, 16'd3,    16'd4, 32'd7, 4'd1, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h2, 2'd1, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd1, 1,  1'b1, 24'd3, 16'd3,    16'd7, 32'd14, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd0, 1,  1'b1, 24'd1, 16'd5,    16'd5, 32'd5, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h4, 4'h0, 2'd2, 9,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd8, 4'h4, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h8, 2'd2, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd8, 4'h4, 4'h8});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd3, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h4, 4'h8});
      tbl.push_back('{1'b1, 4'h4, 4'h4, 2'd2, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd8, 4'h4, 4'h8});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd2, 1,  1'b1, 24'd1, 16'd11,   16'd11, 32'd11, 4'd8, 4'h4, 4'h8});
      tbl.push_back('{1'b1, 4'h8, 4'h8, 2'd3, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd3, 1,  1'b1, 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd1, 4'h4, 4'h8});
      tbl.push_back('{1'b1, 4'h1, 4'h0, 2'd0, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b0, 4'h0, 4'h1, 2'd0, 3,  1'b1, 24'd1, 16'd5,    16'd5, 32'd5, 4'd1, 4'h4, 4'h8});
      tbl.push_back('{1'b1, 4'h0, 4'h1, 2'd0, 1,  1'b0, 24'd0, 16'd0,    16'd0, 32'd0, 4'd0, 4'h0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 4'h0, 2'd0, 1,  1'b1, 24'd2, 16'd1,    16'd5, 32'd6, 4'd0, 4'h4, 4'h8});

      rst_n         = 1'b0;
      bus.en        = 1'b0;
      bus.clr       = 1'b0;
      bus.req_fire  = '0;
      bus.rsp_fire  = '0;
      bus.rd_ch     = '0;
      sbus.en       = 1'b0;
      sbus.clr      = 1'b0;
      sbus.req_fire = '0;
      sbus.rsp_fire = '0;
      sbus.rd_ch    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_main("reset", 24'd0, 16'd0, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0);
      check("reset.s_cnt", 64'(sbus.rd_cnt), 64'd0);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         for (int r = 0; r < tbl[k].rep; r++)
            step(tbl[k].en, 1'b0, tbl[k].req, tbl[k].rsp, tbl[k].ch);
         if (tbl[k].chk)
            check_main($sformatf("row%0d", k), tbl[k].cnt, tbl[k].mn, tbl[k].mx, tbl[k].sum,
                       tbl[k].outst, tbl[k].ovf, tbl[k].unf);
      end

      // clr together with a response: readout lags one edge, flags clear at once.
      step(1'b1, 1'b0, 4'h1, 4'h0, 2'd0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
      step(1'b1, 1'b1, 4'h0, 4'h1, 2'd0);
      check_main("clr_edge", 24'd2, 16'd1, 16'd5, 32'd6, 4'd1, 4'h0, 4'h0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
      check_main("clr_after", 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 4'h0, 4'h0, 2'd2);
      check_main("clr_ch2", 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0);

      // Asynchronous reset with three outstanding requests on ch0.
      repeat (3) step(1'b1, 1'b0, 4'h1, 4'h0, 2'd0);
      #2 rst_n = 1'b0;
      #1;
      check_main("rst_async", 24'd0, 16'd0, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0);
      #1 rst_n = 1'b1;
      step(1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
      check_main("rst_after", 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 4'h0, 4'h1, 2'd0);
      check_main("rst_orphan", 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h1);
      step(1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
      check_main("rst_nostat", 24'd0, 16'hFFFF, 16'd0, 32'd0, 4'd0, 4'h0, 4'h1);
      step(1'b0, 1'b0, 4'h0, 4'h0, 2'd0);

      // Narrow build: first request at tick 14 wraps; later samples push count/sum into saturation.
      repeat (14) s_step(1'b1, 2'b00, 2'b00);
      for (int r = 0; r < 4; r++) begin
         s_step(1'b1, 2'b01, 2'b00);
         repeat (3) s_step(1'b1, 2'b00, 2'b00);
         s_step(1'b1, 2'b00, 2'b01);
         s_step(1'b1, 2'b00, 2'b00);
         check($sformatf("small%0d.cnt", r),   64'(sbus.rd_cnt),   64'(s_cnt_exp[r]));
         check($sformatf("small%0d.sum", r),   64'(sbus.rd_sum),   64'(s_sum_exp[r]));
         check($sformatf("small%0d.min", r),   64'(sbus.rd_min),   64'd4);
         check($sformatf("small%0d.max", r),   64'(sbus.rd_max),   64'd4);
         check($sformatf("small%0d.outst", r), 64'(sbus.rd_outst), 64'd0);
      end
      check("small.unf", 64'(sbus.err_unf), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
